adc_spi_rd: RTL and testbench

//  Serial read-side master for a 16-bit SPI ADC feeding the classification datapath.

---
 rtl/adc_spi_rd.sv | 159 +++++++++++++++
 tb/tb_adc_spi_rd.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_spi_rd.sv
// Read-side SPI master for a 16-bit conversion ADC.
// Pulses cnv, frames cs/sck, shifts the sample in MSB first, strobes data_valid.
module adc_spi_rd #(
  parameter int DATA_W  = 16,
  parameter int SCK_DIV = 4,
  parameter int T_CONV  = 8,
  parameter int T_CS    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_state,
  input  logic              start,
  input  logic              adc_sdo,
  output logic              cnv,
  output logic              cs,
  output logic              sck,
  output logic [4:0]        cnt_sck,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              busy
);

  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONV,
    S_CSU,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       tmr_q, tmr_d;
  logic              sck_q, sck_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] shf_q, shf_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dv_q, dv_d;
  logic              cnv_q, cnv_d;
  logic              cs_q, cs_d;
  logic              busy_q, busy_d;
  logic [BW-1:0]     bidx;

  assign bidx = BW'(DATA_W - 1) - BW'(cnt_q);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    sck_d   = sck_q;
    cnt_d   = cnt_q;
    shf_d   = shf_q;
    dout_d  = dout_q;
    dv_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CONV;
          tmr_d   = '0;
        end
      end
      S_CONV: begin
        if (tmr_q == 16'(T_CONV - 1)) begin
          state_d = S_CSU;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_CSU: begin
        sck_d = 1'b0;
        if (tmr_q == 16'(T_CS - 1)) begin
          state_d = S_SHIFT;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_SHIFT: begin
        if (tmr_q == 16'(SCK_DIV - 1)) begin
          tmr_d = '0;
          if (!sck_q) begin
            // rising sck edge: ADC data is stable here
            sck_d       = 1'b1;
            shf_d[bidx] = adc_sdo;
            cnt_d       = cnt_q + 5'd1;
          end else begin
            sck_d = 1'b0;
            if (cnt_q == 5'(DATA_W)) begin
              state_d = S_DONE;
              dout_d  = shf_q;
              dv_d    = 1'b1;
              cnt_d   = '0;
            end
          end
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // run enable low discards everything, including the last sample
    if (!key_state) begin
      state_d = S_IDLE;
      tmr_d   = '0;
      sck_d   = 1'b0;
      cnt_d   = '0;
      shf_d   = '0;
      dout_d  = '0;
      dv_d    = 1'b0;
    end

    cnv_d  = (state_d == S_CONV);
    cs_d   = !((state_d == S_CSU) || (state_d == S_SHIFT));
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      sck_q   <= 1'b0;
      cnt_q   <= '0;
      shf_q   <= '0;
      dout_q  <= '0;
      dv_q    <= 1'b0;
      cnv_q   <= 1'b0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      sck_q   <= sck_d;
      cnt_q   <= cnt_d;
      shf_q   <= shf_d;
      dout_q  <= dout_d;
      dv_q    <= dv_d;
      cnv_q   <= cnv_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
    end
  end

  assign cnv        = cnv_q;
  assign cs         = cs_q;
  assign sck        = sck_q;
  assign cnt_sck    = cnt_q;
  assign data_out   = dout_q;
  assign data_valid = dv_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_adc_spi_rd.sv
// Bench for adc_spi_rd: ADC serial model, per-cycle framing checks,
// sample scoreboard and abort/reset corner cases.
module tb_adc_spi_rd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_state = 1'b1;
  logic        start = 1'b0;
  logic        adc_sdo;
  logic        cnv, cs, sck, data_valid, busy;
  logic [4:0]  cnt_sck;
  logic [15:0] data_out;

  adc_spi_rd dut (
    .clk(clk), .rst_n(rst_n), .key_state(key_state), .start(start),
    .adc_sdo(adc_sdo), .cnv(cnv), .cs(cs), .sck(sck), .cnt_sck(cnt_sck),
    .data_out(data_out), .data_valid(data_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  // ADC model: MSB presented at cs fall, next bit after each sck fall
  logic [15:0] adc_word = 16'h0000;
  logic [4:0]  bit_i = 5'd0;
  logic [3:0]  idx;
  always @(negedge sck or posedge cs) begin
    if (cs) bit_i <= 5'd0;
    else    bit_i <= bit_i + 5'd1;
  end
  assign idx     = 4'(5'd15 - bit_i);
  assign adc_sdo = (bit_i < 5'd16) ? adc_word[idx] : 1'b0;

  int vecs = 0;
  int errs = 0;
  int dv_cnt = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: every data_valid must match the oldest pushed sample
  always @(negedge clk) begin
    if (rst_n && data_valid === 1'b1) begin
      dv_cnt++;
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL sb_unexpected: got valid %0h expected none", data_out);
      end else begin
        chk("sb_data", 32'(data_out), 32'(exp_q.pop_front()));
      end
    end
  end

  // called at a negedge; start is sampled at the next edge (cycle 1 follows)
  task automatic timed_frame(input logic [15:0] w, input string tag,
                             input bit restart, input bit extra);
    int e_cnv = 0, e_cs = 0, e_dv = 0, e_busy = 0, rises = 0;
    logic psck = 1'b0;
    logic [4:0] c138 = 5'd0;
    adc_word = w;
    exp_q.push_back(w);
    start = 1'b1;
    for (int c = 1; c <= 139; c++) begin
      @(negedge clk);
      start = (extra && (c == 5 || c == 60)) || (restart && c == 139);
      if (cnv !== (c <= 8)) e_cnv++;
      if (cs !== !(c >= 9 && c <= 138)) e_cs++;
      if (data_valid !== (c == 139)) e_dv++;
      if (busy !== 1'b1) e_busy++;
      if (sck && !psck) rises++;
      psck = sck;
      if (c == 138) c138 = cnt_sck;
    end
    chk({tag, "_cnv"}, e_cnv, 0);
    chk({tag, "_cs"}, e_cs, 0);
    chk({tag, "_dv"}, e_dv, 0);
    chk({tag, "_busy"}, e_busy, 0);
    chk({tag, "_rises"}, rises, 16);
    chk({tag, "_cnt16"}, 32'(c138), 16);
    chk({tag, "_dout"}, 32'(data_out), 32'(w));
  endtask

  typedef struct {
    logic [15:0] adc;
    logic [15:0] exp_out;
  } vec_t;
  vec_t tbl[4];

  initial begin
    int n0;
    bit hit;
    tbl[0] = '{16'hA5C3, 16'hA5C3};
    tbl[1] = '{16'h0000, 16'h0000};
    tbl[2] = '{16'hFFFF, 16'hFFFF};
    tbl[3] = '{16'h8001, 16'h8001};

    repeat (3) @(negedge clk);
    chk("rst_cs", cs, 1);
    chk("rst_cnv", cnv, 0);
    chk("rst_sck", sck, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_dout", 32'(data_out), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T2 + T3: single reads then back-to-back frames
    for (int i = 0; i < 4; i++) begin
      timed_frame(tbl[i].adc, $sformatf("vec%0d", i), 1'b0, 1'b0);
      chk($sformatf("vec%0d_out", i), 32'(data_out), 32'(tbl[i].exp_out));
      @(negedge clk);
      chk($sformatf("vec%0d_hold", i), 32'(data_out), 32'(tbl[i].exp_out));
    end

    // T4: start pulses while busy are dropped
    n0 = dv_cnt;
    timed_frame(16'h3C5A, "busy_start", 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    chk("busy_one_dv", dv_cnt - n0, 1);
    chk("busy_idle", busy, 0);

    // T6: start in DONE ignored, start one cycle later runs normally
    timed_frame(16'h1234, "done_a", 1'b1, 1'b0);
    @(negedge clk);
    chk("done_idle", busy, 0);
    timed_frame(16'hFEDC, "done_b", 1'b0, 1'b0);
    @(negedge clk);

    // start coinciding with key_state fall: abort wins
    start = 1'b1;
    key_state = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("race_busy", busy, 0);
    chk("race_cnv", cnv, 0);
    key_state = 1'b1;
    @(negedge clk);
    chk("race_stay_idle", busy, 0);
    timed_frame(16'h0F0F, "pre_abort", 1'b0, 1'b0);
    @(negedge clk);

    // T5: abort at the 7th sck rise
    n0 = dv_cnt;
    adc_word = 16'h5555;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 200 && !hit; c++) begin
      @(negedge clk);
      if (cnt_sck == 5'd7) hit = 1'b1;
    end
    chk("abort_reach7", 32'(hit), 1);
    key_state = 1'b0;
    @(negedge clk);
    chk("abort_cs", cs, 1);
    chk("abort_sck", sck, 0);
    chk("abort_cnt", 32'(cnt_sck), 0);
    chk("abort_busy", busy, 0);
    chk("abort_dout", 32'(data_out), 0);
    repeat (10) @(negedge clk);
    key_state = 1'b1;
    repeat (160) @(negedge clk);
    chk("abort_no_dv", dv_cnt - n0, 0);
    chk("abort_no_restart", busy, 0);
    timed_frame(16'hC0DE, "post_abort", 1'b0, 1'b0);
    @(negedge clk);

    // T1: async reset mid-SHIFT
    adc_word = 16'h7777;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    chk("mid_pre_cs", cs, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_cs", cs, 1);
    chk("arst_sck", sck, 0);
    chk("arst_cnv", cnv, 0);
    chk("arst_busy", busy, 0);
    chk("arst_dout", 32'(data_out), 0);
    chk("arst_cnt", 32'(cnt_sck), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
